// File: rtl/divider_pkg.sv
// Shared types for the iterative 32-bit divider: operation codes, FSM states
// and small helpers that decode the operation.
package divider_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  // DIV and REM treat operands as two's complement; the U variants do not.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder; DIV and DIVU return the quotient.
  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/divider_adder.sv
// Plain 32-bit ripple adder with carry in/out; the divider feeds it an
// inverted divisor with cin=1 to form a trial subtraction.
module divider_adder (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] total;

  assign total = {1'b0, x} + {1'b0, y} + {32'd0, cin};
  assign sum   = total[31:0];
  assign cout  = total[32];

endmodule

// File: rtl/divider.sv
// Iterative restoring radix-2 divider for RISC-V style DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes on capture, 32 CALC steps build the
// quotient and remainder, and FIX restores the signs before DONE.
module divider
  import divider_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t      state;
  state_t      state_nxt;
  op_t         op_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] div_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic [4:0]  count_q;
  logic [31:0] result_q;

  logic        in_signed;
  logic        div_zero;
  logic        overflow;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  logic [31:0] shifted;
  logic [31:0] trial_sum;
  logic        trial_cout;
  logic        take;
  logic [31:0] fixed_quo;
  logic [31:0] fixed_rem;

  // Decode the operands presented at start; only used while IDLE accepts.
  always_comb begin
    in_signed = is_signed_op(op);
    div_zero  = (b == 32'd0);
    overflow  = in_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    mag_a     = (in_signed && a[31]) ? (32'd0 - a) : a;
    mag_b     = (in_signed && b[31]) ? (32'd0 - b) : b;
  end

  // The shifted partial remainder is 33 bits wide: its top bit is rem_q[31].
  // The difference always fits in 32 bits because the partial remainder is
  // below twice the divisor, so the step is kept when that top bit or the
  // adder carry shows the subtraction did not borrow.
  assign shifted = {rem_q[30:0], quo_q[31]};

  divider_adder u_adder (
    .x    (shifted),
    .y    (~div_q),
    .cin  (1'b1),
    .sum  (trial_sum),
    .cout (trial_cout)
  );

  assign take      = rem_q[31] | trial_cout;
  assign fixed_quo = neg_quo_q ? (32'd0 - quo_q) : quo_q;
  assign fixed_rem = neg_rem_q ? (32'd0 - rem_q) : rem_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: special cases skip straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (div_zero || overflow) ? DONE : CALC;
      CALC: if (count_q == 5'd31) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, sign fix.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= DIV;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      div_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      count_q   <= 5'd0;
      result_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op_t'(op);
            quo_q     <= mag_a;
            rem_q     <= 32'd0;
            div_q     <= mag_b;
            neg_quo_q <= in_signed && (a[31] ^ b[31]);
            neg_rem_q <= in_signed && a[31];
            count_q   <= 5'd0;
            if (div_zero)
              result_q <= is_rem_op(op) ? a : 32'hFFFF_FFFF;
            else if (overflow)
              result_q <= is_rem_op(op) ? 32'd0 : 32'h8000_0000;
          end
        end
        CALC: begin
          rem_q   <= take ? trial_sum : shifted;
          quo_q   <= {quo_q[30:0], take};
          count_q <= count_q + 5'd1;
        end
        FIX: begin
          result_q <= is_rem_op(op_q) ? fixed_rem : fixed_quo;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_divider.sv
// Directed testbench for the divider: hand-computed quotients/remainders,
// latency from the accepting edge, special cases, ignored starts and reset.
module tb_divider;
  import divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int fails  = 0;

  divider dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request for the next rising edge, then scramble the inputs
  // so that anything not captured at acceptance would corrupt the result.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] aa,
                               input logic [31:0] bb);
    op    = o;
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~o;
    a     = ~aa;
    b     = bb ^ 32'h5A5A_5A5A;
  endtask

  // Count falling edges after the accepting edge until done, bounded.
  task automatic waitDone(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
  endtask

  // One full operation: latency, result, single-cycle done and hold.
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] exp, input int exp_lat);
    int lat;
    applyStimulus(o, aa, bb);
    waitDone(lat);
    checkOutput({tag, " latency"}, lat, exp_lat);
    checkOutput({tag, " result"}, result, exp);
    @(negedge clk);
    checkOutput({tag, " done drop"}, {31'd0, done}, 32'd0);
    checkOutput({tag, " busy drop"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " hold"}, result, exp);
  endtask

  initial begin
    int pulses;
    int dlat;
    bit seen_done;

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic unsigned and signed cases.
    runOp("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 34);
    runOp("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 34);
    runOp("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    runOp("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    runOp("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    runOp("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    runOp("div -7/-2", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 34);
    runOp("rem -7/-2", REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34);

    // Divide by zero and signed overflow take the one-cycle path.
    runOp("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("remu 5/0", REMU, 32'd5, 32'd0, 32'd5, 1);
    runOp("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Boundary magnitudes.
    runOp("divu ovf operands", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    runOp("remu ovf operands", REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    runOp("div min/1", DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 34);
    runOp("rem min/3", REM, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 34);
    runOp("div min/3", DIV, 32'h8000_0000, 32'd3, 32'hD555_5556, 34);
    runOp("divu max/max", DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 34);
    runOp("remu max/min", REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 34);

    // Starts while busy (cycle k+10) and during DONE are ignored.
    pulses = 0;
    dlat   = 0;
    op     = DIVU;
    a      = 32'd1000;
    b      = 32'd10;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'd7;
    b     = 32'd0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (dlat == 0) begin
          dlat = i;
          checkOutput("busy-start result", result, 32'd100);
        end
      end
      if (dlat != 0 && i == dlat + 1)
        checkOutput("start in DONE ignored", {31'd0, busy}, 32'd0);
      start = (i == 10) || done;
    end
    start = 1'b0;
    checkOutput("busy-start latency", dlat, 34);
    checkOutput("busy-start pulses", pulses, 1);

    // Reset at cycle k+20 abandons the division without a done pulse.
    seen_done = 1'b0;
    op    = DIVU;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    if (done) seen_done = 1'b1;
    checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
    checkOutput("mid reset done", {31'd0, done}, 32'd0);
    checkOutput("mid reset result", result, 32'd0);
    checkOutput("mid reset no done", {31'd0, seen_done}, 32'd0);
    runOp("divu max/1 after reset", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    op    = DIV;
    a     = 32'd5;
    b     = 32'd0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst over start busy", {31'd0, busy}, 32'd0);
    checkOutput("rst over start done", {31'd0, done}, 32'd0);
    checkOutput("rst over start result", result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: none; width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only while IDLE.
REQ-005 op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 a  input  32  dividend; captured on the accepted start.
REQ-007 b  input  32  divisor; captured on the accepted start.
REQ-008 busy  output  1  high whenever state != IDLE.
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 result  output  32  quotient or remainder per the captured op.

Function
REQ-011 States SHALL be IDLE, CALC, FIX and DONE; the encoding is free.
REQ-012 IDLE: start=1 SHALL capture a, b and op; the next state is CALC, or DONE for the special cases in REQ-017 and REQ-018.
REQ-013 A start accepted at edge k SHALL give CALC in cycles k+1..k+32, FIX at k+33 and DONE at k+34; IDLE returns at k+35.
REQ-014 CALC SHALL perform one restoring radix-2 step per cycle on magnitudes: shift the remainder left with the next dividend bit, trial-subtract the divisor, keep the result if non-negative, and shift the quotient bit in.
REQ-015 FIX (signed ops only) SHALL negate the quotient when sign(a)!=sign(b) and negate the remainder when a is negative; the remainder sign SHALL always follow the dividend.
REQ-016 DONE SHALL assert done=1 for exactly one cycle; result SHALL hold its value until the next done.
REQ-017 Divisor zero (any op) SHALL go IDLE->DONE with a 1-cycle latency: DIV/DIVU result 0xFFFFFFFF; REM/REMU result a.
REQ-018 DIV/REM with a=0x80000000 and b=0xFFFFFFFF SHALL go IDLE->DONE with a 1-cycle latency: DIV result 0x80000000; REM result 0.
REQ-019 start SHALL be ignored in every state except IDLE, including DONE; no queueing.
REQ-020 Captured operands SHALL be insensitive to a, b and op changes after acceptance.
REQ-021 Magnitude of 0x80000000 for signed ops SHALL be 0x80000000 and be treated as unsigned 33-bit-safe.
REQ-022 The iteration counter SHALL be 5 bits and terminate CALC after exactly 32 steps; no early exit.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, counter=0, regardless of state.
REQ-024 Reset mid-operation SHALL abandon the division with no done pulse; a start in the first cycle after rst deasserts SHALL be accepted.
REQ-025 rst SHALL take priority over start in the same cycle.

Structure
REQ-026 A shared package SHALL hold the op enum (DIV, DIVU, REM, REMU) and the state enum.
REQ-027 The trial subtraction SHALL instantiate the existing 32-bit adder block with inverted divisor and cin=1; no other sub-modules.
REQ-028 No combinational path from start, a or b to any output SHALL exist.

Verification
REQ-029 DIVU with a=100 and b=7 -> done at k+34 with result 14; REMU with the same operands -> 2.
REQ-030 DIV with a=-7 and b=2 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
REQ-031 DIV with a=5 and b=0 -> done at k+1 with result 0xFFFFFFFF; REMU with a=5 and b=0 -> 5.
REQ-032 DIV with a=0x80000000 and b=0xFFFFFFFF -> done at k+1 with result 0x80000000; REM with the same operands -> 0.
REQ-033 Drive start while busy at cycle k+10 and again in the DONE cycle -> both are ignored; exactly one done pulse.
REQ-034 Assert rst at cycle k+20 -> next cycle busy=0, done=0, result=0; DIVU 0xFFFFFFFF/1 then completes with 0xFFFFFFFF.
